// File: rtl/arb_mux.sv
// arb_mux: multi-channel arbiter/mux with direct or round-robin selection into a one-word output register.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NUM   = 8,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [NUM-1:0]     in_valid,
  output logic [NUM-1:0]     in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_src
);
  logic [SEL_W-1:0] ptr, rr_idx, idx, gidx;
  logic load_en, rr_hit, dir_hit, grant;
  assign load_en = !out_valid || out_ready;
  assign dir_hit = (int'(sel) < NUM) && in_valid[sel];
  // walk ptr+NUM down to ptr+1 so the nearest valid channel after ptr wins
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    idx = '0;
    for (int i = NUM; i >= 1; i--) begin
      idx = SEL_W'((int'(ptr) + i) % NUM);
      if (in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_idx = idx;
      end
    end
  end
  assign gidx = mode ? rr_idx : sel;
  assign grant = !rst && load_en && (mode ? rr_hit : dir_hit);
  assign in_ready = grant ? NUM'(1) << gidx : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      ptr <= SEL_W'(NUM - 1);
    end else if (load_en) begin
      out_valid <= grant;
      if (grant) begin
        out_data <= in_data[int'(gidx)*WIDTH +: WIDTH];
        out_src <= gidx;
        ptr <= gidx;
      end
    end
  end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, as the data width per channel.
REQ-002 The block SHALL provide parameter NUM, default 8, as the number of input channels (2..16).
REQ-003 The block SHALL provide parameter SEL_W, default 3, as the select/index width; the integrator sets it to ceil(log2(NUM)).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port in_data, input, NUM*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, NUM bits, per-channel data-valid.
REQ-008 The block SHALL have port in_ready, output, NUM bits, per-channel accept strobe (combinational).
REQ-009 The block SHALL have port sel, input, SEL_W bits, channel index used in direct mode.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 = direct select, 1 = round-robin.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, registered output word.
REQ-012 The block SHALL have port out_valid, output, 1 bit, output register holds a word.
REQ-013 The block SHALL have port out_ready, input, 1 bit, downstream accepts out_data this cycle.
REQ-014 The block SHALL have port out_src, output, SEL_W bits, index of the channel that supplied out_data.

Function
REQ-015 Transfer on a channel SHALL occur when in_valid[k] and in_ready[k] are both 1 at a rising edge; output transfer when out_valid and out_ready are both 1.
REQ-016 load_en SHALL be (!out_valid) or (out_valid and out_ready); no grant is made when load_en is 0.
REQ-017 Direct mode: grant SHALL go to channel sel iff load_en, sel < NUM and in_valid[sel]; sel >= NUM SHALL produce no grant.
REQ-018 Round-robin mode: grant SHALL go to the first k with in_valid[k] searching ptr+1, ptr+2, ... modulo NUM (wrap from NUM-1 to 0), ptr last.
REQ-019 At most one in_ready bit SHALL be 1 per cycle, namely the granted channel; all others 0.
REQ-020 On a grant, next edge SHALL load out_data = in_data of granted channel, out_src = granted index, out_valid = 1 (latency 1 cycle).
REQ-021 With load_en = 1 and no grant, next edge SHALL set out_valid = 0; out_data and out_src hold their last values.
REQ-022 While out_valid = 1 and out_ready = 0, out_data, out_src, out_valid SHALL remain stable.
REQ-023 Simultaneous output consume and new grant SHALL sustain one word per cycle with no bubble.
REQ-024 ptr SHALL update to the granted index on every grant in either mode; it is unchanged otherwise.
REQ-025 A mode or sel change SHALL affect only the next grant decision, never the word held in the output register.
REQ-026 Fairness: in round-robin mode with all channels continuously valid and out_ready = 1, each channel SHALL be granted once in every NUM consecutive grants.

Reset
REQ-027 With rst = 1 at a rising edge, out_valid = 0, out_data = 0, out_src = 0, ptr = NUM-1 SHALL result, regardless of other inputs.
REQ-028 While rst = 1, in_ready SHALL be all zeros; a word held at reset SHALL be discarded.
REQ-029 First round-robin search after reset SHALL start at channel 0.

Verification
REQ-030 Reset: hold rst 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_src = 0, in_ready = 0; release, mode = 1 -> first out_src = 0.
REQ-031 Direct: mode = 0, sel = 5, in_valid = 8'hFF, ch5 = 32'hA5A5_0005, out_ready = 1 -> in_ready = 8'h20; next cycle out_data = 32'hA5A5_0005, out_src = 5.
REQ-032 Round-robin wrap: mode = 1, in_valid = 8'b1000_0001, out_ready = 1 for 4 grants -> out_src sequence 0, 7, 0, 7.
REQ-033 Backpressure: out_valid = 1 with out_src = 2, out_ready = 0 for 5 cycles while ch2/ch3 data change -> out_data constant, in_ready = 0; out_ready = 1 -> next word loads the same cycle it is consumed.
REQ-034 Invalid select: NUM = 6, mode = 0, sel = 7, in_valid all 1 -> in_ready = 0, out_valid drops to 0 after one consume.
REQ-035 Full throughput: mode = 1, in_valid all 1, out_ready = 1 for 16 cycles -> out_valid = 1 every cycle after the first, out_src 0..7, 0..7.
